// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART Tx arbiter.
//   state_e  : 2-bit FSM state encoding (IDLE, GRANT, SEND, RELEASE)
//   id_width : index width for a count of items, never less than 1 bit
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StSend    = 2'd2,
    StRelease = 2'd3
  } state_e;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector.
// Searches valid[] starting at (last+1) mod NUM_REQ, wrapping, and reports the
// first set position.
//   valid : request vector
//   last  : index granted most recently
//   grant : one-hot of the selected requester (all zero when nothing valid)
//   idx   : index of the selected requester (0 when nothing valid)
module rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]               valid,
  input  logic [id_width(NUM_REQ)-1:0]     last,
  output logic [NUM_REQ-1:0]               grant,
  output logic [id_width(NUM_REQ)-1:0]     idx
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  always_comb begin : p_select
    int unsigned pos;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    // Offsets 1..NUM_REQ so the last-granted requester is checked last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      pos = (32'(last) + k) % NUM_REQ;
      if (!found && valid[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// Works purely in the sys_clk domain; bit timing lives in the UART Tx itself.
//   sys_clk      : clock, rising edge
//   reset        : synchronous active-high reset
//   req_valid    : per-requester frame pending
//   req_data     : requester i frame at [i*FRAME_WIDTH +: FRAME_WIDTH]
//   req_ready    : one-cycle accept pulse to the granted requester
//   uart_tx_en   : transmit enable to the UART Tx
//   uart_tx_din  : frame to the UART Tx
//   uart_tx_done : UART Tx completion level (sys_clk synchronous)
//   busy         : FSM not idle
//   grant_id     : index of the requester last granted
//   timeout_err  : one-cycle pulse when a frame is aborted
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned FRAME_WIDTH    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
  input  logic                             sys_clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*FRAME_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             uart_tx_en,
  output logic [0:FRAME_WIDTH-1]           uart_tx_din,
  input  logic                             uart_tx_done,
  output logic                             busy,
  output logic [id_width(NUM_REQ)-1:0]     grant_id,
  output logic                             timeout_err
);

  localparam int unsigned         IdW     = id_width(NUM_REQ);
  localparam int unsigned         CntW    = id_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0]     CntLast = CntW'(TIMEOUT_CYCLES - 1);
  // Reset to the highest index so requester 0 wins the first search.
  localparam logic [IdW-1:0]      IdReset = IdW'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [IdW-1:0]          grant_id_q, grant_id_d;
  logic [FRAME_WIDTH-1:0]  frame_q, frame_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    done_prev_q;
  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic                    en_q, en_d;
  logic                    timeout_q, timeout_d;

  logic [NUM_REQ-1:0]      sel_grant;
  logic [IdW-1:0]          sel_idx;
  logic                    any_valid;
  logic                    done_rise;
  logic                    timeout_hit;

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .valid (req_valid),
    .last  (grant_id_q),
    .grant (sel_grant),
    .idx   (sel_idx)
  );

  assign any_valid   = |req_valid;
  // Completion is the 0->1 transition; a level left high from earlier is ignored.
  assign done_rise   = uart_tx_done & ~done_prev_q;
  assign timeout_hit = (cnt_q == CntLast);

  // State register
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (any_valid) state_d = StGrant;
      StGrant:   state_d = any_valid ? StSend : StIdle;
      StSend:    if (done_rise || timeout_hit) state_d = StRelease;
      StRelease: if (!uart_tx_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output and datapath next values; outputs are registered.
  always_comb begin
    grant_id_d  = grant_id_q;
    frame_d     = frame_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    en_d        = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      StGrant: begin
        if (any_valid) begin
          req_ready_d = sel_grant;
          grant_id_d  = sel_idx;
          frame_d     = req_data[sel_idx*FRAME_WIDTH +: FRAME_WIDTH];
          cnt_d       = '0;
        end
      end
      StSend: begin
        // A done rise takes precedence over a coincident timeout.
        if (done_rise) begin
          en_d = 1'b0;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      grant_id_q  <= IdReset;
      frame_q     <= '0;
      cnt_q       <= '0;
      done_prev_q <= 1'b0;
      req_ready_q <= '0;
      en_q        <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      grant_id_q  <= grant_id_d;
      frame_q     <= frame_d;
      cnt_q       <= cnt_d;
      done_prev_q <= uart_tx_done;
      req_ready_q <= req_ready_d;
      en_q        <= en_d;
      timeout_q   <= timeout_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign uart_tx_en  = en_q;
  // Numeric value is preserved: uart_tx_din[0] carries the frame MSB.
  assign uart_tx_din = frame_q;
  assign busy        = (state_q != StIdle);
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters sharing one UART Tx (2..8).
REQ-002 The block SHALL have parameter FRAME_WIDTH, default 8, bits per frame.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 200_000, sys_clk cycles allowed per frame before abort.
REQ-004 The block SHALL have port sys_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits, per-requester frame pending.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*FRAME_WIDTH bits, requester i's frame in slice [i*FRAME_WIDTH +: FRAME_WIDTH].
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits, one-cycle accept pulse to the granted requester.
REQ-009 The block SHALL have port uart_tx_en, output, 1 bit, enable to the UART Tx.
REQ-010 The block SHALL have port uart_tx_din, output, [0:FRAME_WIDTH-1], frame to the UART Tx.
REQ-011 The block SHALL have port uart_tx_done, input, 1 bit, UART Tx completion level, already synchronous to sys_clk.
REQ-012 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-013 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits, index of the requester last granted.
REQ-014 The block SHALL have port timeout_err, output, 1 bit, one-cycle pulse when a frame is aborted.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT, SEND and RELEASE.
REQ-016 In IDLE with any req_valid high, the FSM SHALL go to GRANT next cycle.
REQ-017 In GRANT, the block SHALL select the first valid index searching round-robin from (grant_id+1) mod NUM_REQ upward with wrap.
- The block SHALL pulse req_ready[sel] for exactly one cycle.
- The block SHALL latch req_data slice sel into the frame register.
- The block SHALL update grant_id and go to SEND.
REQ-018 If req_valid drops before GRANT, the FSM SHALL return to IDLE with no req_ready pulse.
REQ-019 In SEND, uart_tx_en SHALL be held high and uart_tx_din SHALL be held at the latched frame.
REQ-020 SEND SHALL exit on a rising edge of uart_tx_done (registered previous value 0, current 1), not on its level.
REQ-021 On exit from SEND, uart_tx_en SHALL deassert in the next cycle and the FSM SHALL enter RELEASE.
REQ-022 RELEASE SHALL wait until uart_tx_done is low, then go to IDLE; arbitration SHALL NOT occur in RELEASE.
REQ-023 A timeout counter SHALL clear on entry to SEND and increment each SEND cycle.
REQ-024 If the timeout counter reaches TIMEOUT_CYCLES-1 without a done rise, the block SHALL pulse timeout_err, drop uart_tx_en and go to RELEASE.
REQ-025 When a done rise and timeout occur in the same cycle, the done rise SHALL win and timeout_err SHALL stay low.
REQ-026 Latency from req_valid to req_ready SHALL be 2 cycles from IDLE; uart_tx_en SHALL rise in the cycle after req_ready.
REQ-027 req_valid changes during SEND or RELEASE SHALL have no effect on the frame in flight.
REQ-028 A requester holding valid continuously SHALL be granted at most once per NUM_REQ grants while others are pending (fairness).

Reset
REQ-029 Reset SHALL force state to IDLE and clear the timeout counter and the done-edge register.
- Outputs after reset: req_ready=0, uart_tx_en=0, uart_tx_din=0, busy=0, timeout_err=0.
- grant_id after reset SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-030 Reset asserted mid-SEND SHALL drop uart_tx_en on the next edge and discard the latched frame.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2-bit) and the clog2-based ID width helper.
REQ-032 The round-robin selector SHALL be a sub-module rr_select (inputs valid vector and last pointer; outputs one-hot grant and index), purely combinational.
REQ-033 The top-level integration SHALL instantiate this block alongside the existing UART Tx top; no bit_clk logic SHALL reside in this block.

Verification
REQ-034 The bench SHALL cover: reset, then req_valid=4'b0001, data0=8'hA5 -> req_ready[0] pulses 2 cycles later, uart_tx_en high with din=8'hA5 until done rises, then en low.
REQ-035 The bench SHALL cover: req_valid=4'b1111 held, done pulsed per frame -> grant order 0,1,2,3,0.
REQ-036 The bench SHALL cover: grant_id=2, req_valid=4'b0011 -> requester 0 granted (wrap).
REQ-037 The bench SHALL cover: TIMEOUT_CYCLES=16, done never rises -> timeout_err pulses 16 cycles after SEND entry, en low, then IDLE.
REQ-038 The bench SHALL cover: done stuck high from the previous frame -> no completion until it falls and a new rise occurs.
REQ-039 The bench SHALL cover: reset asserted in SEND -> next cycle uart_tx_en=0, busy=0, grant_id=NUM_REQ-1.
